// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and line geometry for the icache-refill / data-port memory arbiter.
package srm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IC_BURST = 2'd1,
        D_ACCESS = 2'd2
    } arb_state_t;

    typedef enum logic {
        GR_IC   = 1'b0,
        GR_DATA = 1'b1
    } grant_t;

    localparam int LINE_BEATS   = 16;
    localparam int LINE_OFF_LSB = 2;
    localparam int LINE_OFF_MSB = 5;
    localparam int BEAT_W       = LINE_OFF_MSB - LINE_OFF_LSB + 1;

    function automatic logic [BEAT_W-1:0] next_beat(input logic [BEAT_W-1:0] beat);
        return beat + BEAT_W'(1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin picker: bit 0 = icache refill, bit 1 = data port; grant is one-hot.
module rr_arb2
    import srm_mem_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_data_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            // Contention: favour whichever side did not win last time.
            2'b11:   grant_o = last_data_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between 16-beat icache line refills and single-word data accesses.
//   state    | meaning
//   IDLE     | mem_req low, arbitrate pending requests
//   IC_BURST | fetching one icache line, beat by beat
//   D_ACCESS | single data read or write in flight
module mem_bus_arbiter
    import srm_mem_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_valid,
    output logic [DATA_W-1:0] ic_data,
    output logic [3:0]        ic_beat,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              dw_we,
    output logic [ADDR_W-1:0] dw_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int LINE_W = ADDR_W - LINE_OFF_MSB - 1;

    arb_state_t        state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [ADDR_W-1:0] dacc_addr_q, dacc_addr_d;

    logic              ic_valid_q, ic_valid_d;
    logic [DATA_W-1:0] ic_data_q, ic_data_d;
    logic [3:0]        ic_beat_q, ic_beat_d;
    logic              d_done_q, d_done_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              dw_we_q, dw_we_d;
    logic [ADDR_W-1:0] dw_addr_q, dw_addr_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [1:0] grant;
    logic       ack;
    logic       unused_ic_offset;

    assign unused_ic_offset = ^ic_addr[LINE_OFF_MSB:0];
    assign ack = mem_ack & mem_req_q;

    rr_arb2 u_rr_arb2 (
        .req_i       ({d_req, ic_req}),
        .last_data_i (last_grant_q == GR_DATA),
        .grant_o     (grant)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beat_d       = beat_q;
        line_d       = line_q;
        dacc_addr_d  = dacc_addr_q;
        ic_valid_d   = 1'b0;
        ic_data_d    = ic_data_q;
        ic_beat_d    = ic_beat_q;
        d_done_d     = 1'b0;
        d_rdata_d    = d_rdata_q;
        dw_we_d      = 1'b0;
        dw_addr_d    = dw_addr_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (grant[0]) begin
                    state_d      = IC_BURST;
                    last_grant_d = GR_IC;
                    line_d       = ic_addr[ADDR_W-1:LINE_OFF_MSB+1];
                    beat_d       = '0;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = {ic_addr[ADDR_W-1:LINE_OFF_MSB+1], {BEAT_W{1'b0}}, 2'b00};
                end else if (grant[1]) begin
                    state_d      = D_ACCESS;
                    last_grant_d = GR_DATA;
                    dacc_addr_d  = d_addr;
                    mem_req_d    = 1'b1;
                    mem_we_d     = d_we;
                    mem_addr_d   = {d_addr[ADDR_W-1:LINE_OFF_LSB], 2'b00};
                    mem_wdata_d  = d_wdata;
                end
            end

            IC_BURST: begin
                // The line base is latched at grant so the fill stays whole even if the
                // icache moves on; ic_req is not consulted until the burst ends.
                if (ack) begin
                    ic_valid_d = 1'b1;
                    ic_data_d  = mem_rdata;
                    ic_beat_d  = beat_q;
                    beat_d     = next_beat(beat_q);
                    mem_addr_d = {line_q, next_beat(beat_q), 2'b00};
                    if (beat_q == BEAT_W'(LINE_BEATS - 1)) begin
                        mem_req_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
            end

            D_ACCESS: begin
                if (ack) begin
                    d_done_d  = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = IDLE;
                    if (mem_we_q) begin
                        dw_we_d   = 1'b1;
                        dw_addr_d = dacc_addr_q;
                    end else begin
                        d_rdata_d = mem_rdata;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GR_DATA;
            beat_q       <= '0;
            line_q       <= '0;
            dacc_addr_q  <= '0;
            ic_valid_q   <= 1'b0;
            ic_data_q    <= '0;
            ic_beat_q    <= '0;
            d_done_q     <= 1'b0;
            d_rdata_q    <= '0;
            dw_we_q      <= 1'b0;
            dw_addr_q    <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
            line_q       <= line_d;
            dacc_addr_q  <= dacc_addr_d;
            ic_valid_q   <= ic_valid_d;
            ic_data_q    <= ic_data_d;
            ic_beat_q    <= ic_beat_d;
            d_done_q     <= d_done_d;
            d_rdata_q    <= d_rdata_d;
            dw_we_q      <= dw_we_d;
            dw_addr_q    <= dw_addr_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign ic_valid  = ic_valid_q;
    assign ic_data   = ic_data_q;
    assign ic_beat   = ic_beat_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign dw_we     = dw_we_q;
    assign dw_addr   = dw_addr_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; memory returns {8'hA5, address} as read data.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        ic_req;
    logic [23:0] ic_addr;
    logic        ic_valid;
    logic [31:0] ic_data;
    logic [3:0]  ic_beat;
    logic        d_req;
    logic        d_we;
    logic [23:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        dw_we;
    logic [23:0] dw_addr;
    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int total;
    int bad;

    mem_bus_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .ic_req    (ic_req),
        .ic_addr   (ic_addr),
        .ic_valid  (ic_valid),
        .ic_data   (ic_data),
        .ic_beat   (ic_beat),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .dw_we     (dw_we),
        .dw_addr   (dw_addr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    assign mem_rdata = {8'hA5, mem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one line fill with ack every cycle; call at a negedge where the grant edge is next.
    task automatic run_burst(input logic [23:0] base, input bit drop_ic, input int raise_d_at);
        int n;
        int cyc;
        n = 0;
        cyc = 0;
        mem_ack = 1'b1;
        while (n < 16 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (ic_valid) begin
                check("ic_beat", 64'(ic_beat), 64'(n));
                check("ic_data", 64'(ic_data), 64'({8'hA5, base + 24'(4 * n)}));
                n++;
                if (n == raise_d_at) d_req = 1'b1;
            end
            if (mem_req) begin
                check("ic_mem_addr", 64'(mem_addr), 64'(base + 24'(4 * (n % 16))));
                check("ic_mem_we", 64'(mem_we), 64'(0));
            end
        end
        check("ic_beats", 64'(n), 64'(16));
        check("ic_gap_req", 64'(mem_req), 64'(0));
        if (drop_ic) ic_req = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        ic_req  = 1'b0;
        ic_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        mem_ack = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_ic_valid", 64'(ic_valid), 64'(0));
        check("rst_d_done", 64'(d_done), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle_mem_req", 64'(mem_req), 64'(0));

        // 1: single line fill, offset in the miss address ignored
        ic_req  = 1'b1;
        ic_addr = 24'h0012C4;
        run_burst(24'h0012C0, 1'b1, -1);
        mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t1_idle_req", 64'(mem_req), 64'(0));

        // 2: read with three wait cycles
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 24'h000104;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_req", 64'(mem_req), 64'(1));
            check("t2_we", 64'(mem_we), 64'(0));
            check("t2_addr", 64'(mem_addr), 64'(24'h000104));
            check("t2_no_done", 64'(d_done), 64'(0));
        end
        mem_ack = 1'b1;
        @(negedge clk);
        check("t2_done", 64'(d_done), 64'(1));
        check("t2_rdata", 64'(d_rdata), 64'(32'hA5000104));
        check("t2_no_dw", 64'(dw_we), 64'(0));
        d_req   = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        check("t2_done_pulse", 64'(d_done), 64'(0));
        check("t2_rdata_hold", 64'(d_rdata), 64'(32'hA5000104));

        // 3: write, invalidate reported with completion
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 24'h000204;
        d_wdata = 32'hDEADBEEF;
        mem_ack = 1'b1;
        @(negedge clk);
        check("t3_req", 64'(mem_req), 64'(1));
        check("t3_we", 64'(mem_we), 64'(1));
        check("t3_addr", 64'(mem_addr), 64'(24'h000204));
        check("t3_wdata", 64'(mem_wdata), 64'(32'hDEADBEEF));
        @(negedge clk);
        check("t3_done", 64'(d_done), 64'(1));
        check("t3_dw_we", 64'(dw_we), 64'(1));
        check("t3_dw_addr", 64'(dw_addr), 64'(24'h000204));
        check("t3_rdata_kept", 64'(d_rdata), 64'(32'hA5000104));
        d_req   = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        check("t3_dw_pulse", 64'(dw_we), 64'(0));

        // 4: contention after reset -> IC, DATA, IC, DATA with both held
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        ic_req  = 1'b1;
        ic_addr = 24'h000400;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 24'h000300;
        run_burst(24'h000400, 1'b0, -1);
        @(negedge clk);
        check("t4_d_addr", 64'(mem_addr), 64'(24'h000300));
        check("t4_d_req", 64'(mem_req), 64'(1));
        @(negedge clk);
        check("t4_d_done", 64'(d_done), 64'(1));
        check("t4_d_rdata", 64'(d_rdata), 64'(32'hA5000300));
        run_burst(24'h000400, 1'b1, -1);
        @(negedge clk);
        check("t4_d2_addr", 64'(mem_addr), 64'(24'h000300));
        @(negedge clk);
        check("t4_d2_done", 64'(d_done), 64'(1));
        d_req   = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);

        // 5: data request during a burst waits for the whole line
        ic_req  = 1'b1;
        ic_addr = 24'h000A08;
        d_we    = 1'b1;
        d_addr  = 24'h000510;
        d_wdata = 32'h12345678;
        run_burst(24'h000A00, 1'b1, 5);
        @(negedge clk);
        check("t5_d_req", 64'(mem_req), 64'(1));
        check("t5_d_we", 64'(mem_we), 64'(1));
        check("t5_d_addr", 64'(mem_addr), 64'(24'h000510));
        check("t5_d_wdata", 64'(mem_wdata), 64'(32'h12345678));
        @(negedge clk);
        check("t5_done", 64'(d_done), 64'(1));
        check("t5_dw_addr", 64'(dw_addr), 64'(24'h000510));
        d_req   = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);

        // 6: reset in the middle of a burst, then a clean restart at beat 0
        begin
            int n;
            int cyc;
            n = 0;
            cyc = 0;
            ic_req  = 1'b1;
            ic_addr = 24'h000800;
            mem_ack = 1'b1;
            while (n < 8 && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (ic_valid) n++;
            end
            check("t6_reach_beat8", 64'(n), 64'(8));
        end
        #2 rst = 1'b1;
        #1;
        check("t6_rst_req", 64'(mem_req), 64'(0));
        check("t6_rst_addr", 64'(mem_addr), 64'(0));
        check("t6_rst_valid", 64'(ic_valid), 64'(0));
        @(negedge clk);
        check("t6_hold_req", 64'(mem_req), 64'(0));
        check("t6_hold_valid", 64'(ic_valid), 64'(0));
        rst = 1'b0;
        run_burst(24'h000800, 1'b1, -1);
        mem_ack = 1'b0;
        @(negedge clk);
        check("t6_end_done", 64'(d_done), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
